// File: rtl/adder_arb_pkg.sv
// Shared types and defaults for the adder arbiter: FSM state encoding,
// default sizing and the ID-width helper.
package adder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 64;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/adder_arbiter_rr.sv
// Combinational round-robin pick: first requester after last_grant_i,
// wrapping, with a one-hot grant and its index.
module rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]          req_i,
    input  logic [clog2(NREQ)-1:0]   last_grant_i,
    input  logic                     en_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic [clog2(NREQ)-1:0]   gnt_idx_o
);

    localparam int IDW = clog2(NREQ);

    always_comb begin
        logic found;
        int   idx;
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = 0;
        if (en_i) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (int'(last_grant_i) + k) % NREQ;
                if (!found && req_i[idx]) begin
                    found      = 1'b1;
                    gnt_o[idx] = 1'b1;
                    gnt_idx_o  = IDW'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one external combinational adder among NREQ requesters: grant,
// register operands onto the adder, capture the result, return it tagged.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ-1:0]         req_cin,
    output logic [WIDTH-1:0]        add_a,
    output logic [WIDTH-1:0]        add_b,
    output logic                    add_cin,
    input  logic [WIDTH-1:0]        add_sum,
    input  logic                    add_cout,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [clog2(NREQ)-1:0]  resp_id,
    output logic [WIDTH-1:0]        resp_sum,
    output logic                    resp_cout
);

    localparam int IDW = clog2(NREQ);

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             cin_q, cout_q, rvld_q;
    logic [IDW-1:0]   id_q, last_q;

    logic             arb_en, accept;
    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_idx;
    int               sel;

    // rst_n gates the enable so req_ready drops the instant reset asserts.
    assign arb_en = rst_n && ((state_q == IDLE) || (state_q == RESP && resp_ready));
    assign accept = |gnt;
    assign sel    = int'(gnt_idx);

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req_i        (req_valid),
        .last_grant_i (last_q),
        .en_i         (arb_en),
        .gnt_o        (gnt),
        .gnt_idx_o    (gnt_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            id_q    <= '0;
            last_q  <= IDW'(NREQ - 1);
            sum_q   <= '0;
            cout_q  <= 1'b0;
            rvld_q  <= 1'b0;
        end else begin
            if (accept) begin
                a_q    <= req_a[sel*WIDTH +: WIDTH];
                b_q    <= req_b[sel*WIDTH +: WIDTH];
                cin_q  <= req_cin[sel];
                id_q   <= gnt_idx;
                last_q <= gnt_idx;
            end
            case (state_q)
                IDLE: if (accept) state_q <= EXEC;
                EXEC: begin
                    sum_q   <= add_sum;
                    cout_q  <= add_cout;
                    rvld_q  <= 1'b1;
                    state_q <= RESP;
                end
                RESP: if (resp_ready) begin
                    rvld_q  <= 1'b0;
                    state_q <= accept ? EXEC : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = gnt;
    assign add_a      = a_q;
    assign add_b      = b_q;
    assign add_cin    = cin_q;
    assign resp_valid = rvld_q;
    assign resp_id    = id_q;
    assign resp_sum   = sum_q;
    assign resp_cout  = cout_q;

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares one combinational 64-bit prefix adder among NREQ requesters. It accepts operand requests over per-requester valid/ready handshakes and registers the granted operands onto the adder inputs. It captures sum and carry-out, then returns them on a single shared response channel tagged with the requester ID. It sits between the execution-side requesters and the adder instance, which is external to this block.

## Interface
- NREQ, 4, number of requesters (≥2)
- WIDTH, 64, operand/sum width; must match the attached adder
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- req_a  in  NREQ*WIDTH  operand A, requester i at [WIDTH*(i+1)-1:WIDTH*i]
- req_b  in  NREQ*WIDTH  operand B, same packing
- req_cin  in  NREQ  carry-in per requester
- add_a  out  WIDTH  to adder operand A (registered)
- add_b  out  WIDTH  to adder operand B (registered)
- add_cin  out  1  to adder carry-in (registered)
- add_sum  in  WIDTH  from adder sum (combinational from add_a/add_b/add_cin)
- add_cout  in  1  from adder carry-out
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumer ready
- resp_id  out  clog2(NREQ)  index of requester the response belongs to
- resp_sum  out  WIDTH  registered sum
- resp_cout  out  1  registered carry-out

## Operation
- FSM states: IDLE, EXEC, RESP.
- Grant rule:
  - Eligible in IDLE, or in RESP on the cycle resp_ready=1.
  - Grant goes to the first i with req_valid[i], searching from (last_grant+1) mod NREQ upward with wrap.
  - req_ready[g] is asserted combinationally that cycle only.
- Acceptance (req_valid[g] & req_ready[g]):
  - Latch req_a/req_b/req_cin[g] into the operand registers.
  - Latch g into the ID register and into last_grant.
  - Next state is EXEC.
- IDLE with no valid: stay in IDLE; req_ready all 0; last_grant unchanged.
- EXEC: operand registers drive add_*. At the cycle end, latch add_sum→resp_sum and add_cout→resp_cout. Next state is RESP.
- RESP: resp_valid=1; resp_id/resp_sum/resp_cout are held stable until the handshake completes.
  - resp_ready=1 with any req_valid: new grant the same cycle, next state EXEC.
  - resp_ready=1 with no req_valid: next state IDLE.
  - resp_ready=0: stay in RESP; req_ready all 0.
- Arithmetic:
  - resp_sum = (a+b+cin) mod 2^WIDTH.
  - resp_cout = bit WIDTH of the full sum.
  - The block performs no arithmetic itself.
- Requesters may drop req_valid before being granted without penalty. Operands are sampled only at acceptance.
- Reset (any time, including mid-EXEC or mid-RESP):
  - State goes to IDLE; the in-flight transaction is dropped with no response.
  - last_grant resets to NREQ-1, so requester 0 has first priority.
  - Operand, ID and result registers reset to 0.
  - resp_valid=0 and req_ready=0 immediately on rst_n low.

## Timing
- Request accepted in cycle T → resp_valid high in cycle T+2.
- Sustained throughput: one transaction per 2 cycles with resp_ready held high.
- Single combinational adder delay budget: add_a → add_sum within one clock period. add_* are driven from flops only.
- req_ready depends combinationally on req_valid, state, last_grant and resp_ready. It never depends on req_a/req_b.
- Reset values: req_ready=0, add_a=0, add_b=0, add_cin=0, resp_valid=0, resp_id=0, resp_sum=0, resp_cout=0.

## Structure
- Package adder_arb_pkg holds:
  - the state enum (IDLE, EXEC, RESP);
  - the default NREQ and WIDTH;
  - an ID-width constant function clog2.
- Sub-module rr_arbiter (NREQ): inputs req vector, last_grant and enable; outputs one-hot grant and its index. It is purely combinational.
- The top holds the FSM, operand/ID/result registers and last_grant.

## Test plan
- Basic add: req_valid[0] with a=1, b=2, cin=0 accepted at T → resp_valid at T+2, resp_id=0, resp_sum=3, resp_cout=0.
- Overflow: req_valid[2] with a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=1 → resp_id=2, resp_sum=1, resp_cout=1.
- Fairness: all four req_valid held high, resp_ready=1 → grant order 0,1,2,3,0,1. Acceptances every 2 cycles, each resp_sum correct.
- Backpressure: resp_ready=0 for 5 cycles in RESP → resp_* stable, req_ready=0 throughout. On resp_ready=1, the next requester is granted that cycle.
- Reset mid-EXEC: assert rst_n=0 during EXEC → resp_valid stays 0, all outputs 0 asynchronously. After release, req_valid[3] and req_valid[0] together → requester 0 granted first.
- Withdrawal: req_valid[1] high then low before grant while req 0 is served → requester 1 is never granted, no response with resp_id=1.
